// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the per-axis phase encoding.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  typedef logic [CNT_W-1:0] cnt_t;

  // Same encoding for both axes: ACTIVE->FRONT->SYNC->BACK->ACTIVE
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_phase_counter.sv
// One timing axis: position counter, phase FSM and a wrap strobe.
// The phase register tracks the counter exactly, so sync/active are
// decoded from state rather than from counter compares.
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic   vga_clk,
  input  logic   RST,
  input  logic   en,
  output cnt_t   cnt,
  output phase_e phase,
  output logic   wrap,
  output logic   sync_n,
  output logic   active
);

  localparam int   TOTAL   = VISIBLE + FRONT + SYNC + BACK;
  localparam cnt_t END_ACT = cnt_t'(VISIBLE - 1);
  localparam cnt_t END_FRT = cnt_t'(VISIBLE + FRONT - 1);
  localparam cnt_t END_SYN = cnt_t'(VISIBLE + FRONT + SYNC - 1);
  localparam cnt_t END_TOT = cnt_t'(TOTAL - 1);

  phase_e phase_nx;

  // Last count of the axis while enabled; also drives the next axis
  assign wrap = en && (cnt == END_TOT);

  // Position counter, wraps TOTAL-1 -> 0
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST)    cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
  end

  // Phase state register
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST) phase <= PH_ACTIVE;
    else      phase <= phase_nx;
  end

  // Advance on the last count of each phase
  always_comb begin
    phase_nx = phase;
    if (en) begin
      case (phase)
        PH_ACTIVE: if (cnt == END_ACT) phase_nx = PH_FRONT;
        PH_FRONT:  if (cnt == END_FRT) phase_nx = PH_SYNC;
        PH_SYNC:   if (cnt == END_SYN) phase_nx = PH_BACK;
        PH_BACK:   if (cnt == END_TOT) phase_nx = PH_ACTIVE;
        default:   phase_nx = PH_ACTIVE;
      endcase
    end
  end

  // Phase decodes
  always_comb begin
    sync_n = (phase != PH_SYNC);
    active = (phase == PH_ACTIVE);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: H/V timing axes, one-stage sync/blank delay to
// line up with the pattern generator, registered 4-bit DAC colour.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA640_H_VISIBLE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_VISIBLE = VGA640_V_VISIBLE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK
) (
  input  logic       vga_clk,
  input  logic       RST,
  input  logic [9:0] red_in,
  input  logic [9:0] green_in,
  input  logic [9:0] blue_in,
  output logic [9:0] xPos,
  output logic [9:0] yPos,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       frame_start
);

  phase_e h_phase, v_phase;
  logic   h_wrap, v_wrap;
  logic   h_sync_n, v_sync_n;
  logic   h_act, v_act;
  logic   visible;
  logic   blank_d;
  logic   unused;

  vga_phase_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .vga_clk (vga_clk),
    .RST     (RST),
    .en      (1'b1),
    .cnt     (xPos),
    .phase   (h_phase),
    .wrap    (h_wrap),
    .sync_n  (h_sync_n),
    .active  (h_act)
  );

  // Vertical axis steps only at the end of each line
  vga_phase_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .vga_clk (vga_clk),
    .RST     (RST),
    .en      (h_wrap),
    .cnt     (yPos),
    .phase   (v_phase),
    .wrap    (v_wrap),
    .sync_n  (v_sync_n),
    .active  (v_act)
  );

  assign visible = h_act && v_act;

  // Counters are held at 0,0 in reset, so gating with RST makes the
  // very first pixel after release carry the frame strobe.
  assign frame_start = RST && (xPos == '0) && (yPos == '0);

  // Sync and blank delayed one clock to match red_in/green_in/blue_in
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST) begin
      VGA_HS  <= 1'b1;
      VGA_VS  <= 1'b1;
      blank_d <= 1'b1;
    end else begin
      VGA_HS  <= h_sync_n;
      VGA_VS  <= v_sync_n;
      blank_d <= !visible;
    end
  end

  // DAC colour: low nibble of the pattern, forced to 0 while blanked
  always_ff @(posedge vga_clk or negedge RST) begin
    if (!RST) begin
      VGA_R <= 4'h0;
      VGA_G <= 4'h0;
      VGA_B <= 4'h0;
    end else begin
      VGA_R <= blank_d ? 4'h0 : red_in[3:0];
      VGA_G <= blank_d ? 4'h0 : green_in[3:0];
      VGA_B <= blank_d ? 4'h0 : blue_in[3:0];
    end
  end

  assign unused = ^{red_in[9:4], green_in[9:4], blue_in[9:4],
                    h_phase, v_phase, v_wrap};

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: a default 640x480 instance plus a shrunken-timing instance that
// completes many frames quickly. Both are checked every clock against a
// model that derives position from the cycle count since reset release.
module tb_vga_sync_gen;

  // shrunken timing: H total 31, V total 21, frame 651 clocks
  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 5;
  localparam int SVV = 12, SVF = 3, SVS = 2, SVB = 4;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;

  logic       vga_clk = 1'b0;
  logic       RST = 1'b0;
  logic [9:0] red_in = '0, green_in = '0, blue_in = '0;
  logic [9:0] r_prev = '0, g_prev = '0, b_prev = '0;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_hs, d_vs, d_fs, s_hs, s_vs, s_fs;
  logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

  int n_cmp = 0, n_bad = 0;
  int fs_n = 0, hs_pulses = 0, hs_low = 0, vs_pulses = 0, vs_low = 0;
  logic hs_last = 1'b1, vs_last = 1'b1;

  always #5 vga_clk = ~vga_clk;

  vga_sync_gen u_dflt (
    .vga_clk(vga_clk), .RST(RST),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .xPos(d_x), .yPos(d_y), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .vga_clk(vga_clk), .RST(RST),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .xPos(s_x), .yPos(s_y), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .frame_start(s_fs)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected outputs t clocks after release, from the raster rules:
  // position = t mod line / frame; sync = previous position in the sync
  // window; colour = pattern seen one clock ago, if the pixel two clocks
  // ago was visible.
  task automatic chk_dut(input string nm, input int t,
                         input int hv, input int hf, input int hsw, input int hb,
                         input int vv, input int vf, input int vsw, input int vb,
                         input logic [9:0] x, input logic [9:0] y,
                         input logic hs, input logic vs,
                         input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b, input logic fs);
    int ht, vt, ex, ey, px, py;
    logic ehs, evs, vis2;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    ex = t % ht;
    ey = (t / ht) % vt;
    ehs = 1'b1; evs = 1'b1; vis2 = 1'b0;
    if (t >= 1) begin
      px = (t - 1) % ht;
      py = ((t - 1) / ht) % vt;
      ehs = !(px >= hv + hf && px < hv + hf + hsw);
      evs = !(py >= vv + vf && py < vv + vf + vsw);
    end
    if (t >= 2) begin
      px = (t - 2) % ht;
      py = ((t - 2) / ht) % vt;
      vis2 = (px < hv) && (py < vv);
    end
    chk({nm, ".xPos"}, int'(x), ex);
    chk({nm, ".yPos"}, int'(y), ey);
    chk({nm, ".frame_start"}, int'(fs), (ex == 0 && ey == 0) ? 1 : 0);
    chk({nm, ".VGA_HS"}, int'(hs), int'(ehs));
    chk({nm, ".VGA_VS"}, int'(vs), int'(evs));
    chk({nm, ".VGA_R"}, int'(r), vis2 ? int'(r_prev[3:0]) : 0);
    chk({nm, ".VGA_G"}, int'(g), vis2 ? int'(g_prev[3:0]) : 0);
    chk({nm, ".VGA_B"}, int'(b), vis2 ? int'(b_prev[3:0]) : 0);
  endtask

  task automatic chk_rst(input string nm, input logic [9:0] x, input logic [9:0] y,
                         input logic hs, input logic vs, input logic [3:0] r,
                         input logic [3:0] g, input logic [3:0] b, input logic fs);
    chk({nm, ".xPos"}, int'(x), 0);
    chk({nm, ".yPos"}, int'(y), 0);
    chk({nm, ".VGA_HS"}, int'(hs), 1);
    chk({nm, ".VGA_VS"}, int'(vs), 1);
    chk({nm, ".VGA_RGB"}, int'({r, g, b}), 0);
    chk({nm, ".frame_start"}, int'(fs), 0);
  endtask

  // mode 0: random colours; mode 1: constant 10'h00F, then a white band
  // on small-raster lines 5..7, presented one clock after the pixel.
  task automatic run(input int n, input int mode);
    int py;
    for (int t = 0; t < n; t++) begin
      if (t > 0) @(negedge vga_clk);
      #1;
      chk_dut("dflt", t, 640, 16, 96, 48, 480, 10, 2, 33,
              d_x, d_y, d_hs, d_vs, d_r, d_g, d_b, d_fs);
      chk_dut("small", t, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB,
              s_x, s_y, s_hs, s_vs, s_r, s_g, s_b, s_fs);
      if (mode == 1) begin
        if (t < SFRAME && s_fs) fs_n++;
        if (t >= 1 && t <= SFRAME) begin
          if (!s_hs) hs_low++;
          if (!s_hs && hs_last) hs_pulses++;
          if (!s_vs) vs_low++;
          if (!s_vs && vs_last) vs_pulses++;
        end
        hs_last = s_hs;
        vs_last = s_vs;
      end
      if (mode == 0) begin
        red_in = 10'($urandom); green_in = 10'($urandom); blue_in = 10'($urandom);
      end else if (t < 700) begin
        red_in = 10'h00F; green_in = 10'h00F; blue_in = 10'h00F;
      end else begin
        py = ((t - 1) / SHT) % SVT;
        red_in   = (py >= 5 && py <= 7) ? 10'h3FF : 10'h000;
        green_in = red_in;
        blue_in  = red_in;
      end
      r_prev = red_in; g_prev = green_in; b_prev = blue_in;
    end
  endtask

  initial begin
    // held in reset
    repeat (3) @(negedge vga_clk);
    #1;
    chk_rst("rst.dflt", d_x, d_y, d_hs, d_vs, d_r, d_g, d_b, d_fs);
    chk_rst("rst.small", s_x, s_y, s_hs, s_vs, s_r, s_g, s_b, s_fs);

    // ~4.7 small frames, first 3+ default lines; stops with both
    // instances inside HS (and the small one inside VS)
    @(negedge vga_clk);
    RST = 1'b1;
    run(3092, 0);
    chk("pre.dflt.VGA_HS", int'(d_hs), 0);
    chk("pre.small.VGA_HS", int'(s_hs), 0);
    chk("pre.small.VGA_VS", int'(s_vs), 0);

    // asynchronous reset before the next rising edge
    #2 RST = 1'b0;
    #1;
    chk_rst("async.dflt", d_x, d_y, d_hs, d_vs, d_r, d_g, d_b, d_fs);
    chk_rst("async.small", s_x, s_y, s_hs, s_vs, s_r, s_g, s_b, s_fs);
    repeat (2) begin
      @(negedge vga_clk);
      #1;
      chk_rst("hold.small", s_x, s_y, s_hs, s_vs, s_r, s_g, s_b, s_fs);
    end

    // restart: full small frame + wrap into the next, colour patterns
    @(negedge vga_clk);
    RST = 1'b1;
    run(1400, 1);
    chk("frame.frame_start_count", fs_n, 1);
    chk("frame.hs_pulses", hs_pulses, SVT);
    chk("frame.hs_low_clocks", hs_low, SVT * SHS);
    chk("frame.vs_pulses", vs_pulses, 1);
    chk("frame.vs_low_clocks", vs_low, SVS * SHT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync pulse clocks.
REQ-004 Parameter H_BACK, default 48, horizontal back porch clocks.
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync pulse lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch lines.
REQ-009 vga_clk  in  1  pixel clock, 25.175 MHz nominal; the only clock.
REQ-010 RST  in  1  reset, asynchronous, active-low.
REQ-011 red_in, green_in, blue_in  in  10 each  pixel colour from the pattern generator, valid one clock after the matching xPos/yPos.
REQ-012 xPos  out  10  current horizontal count, 0..H_TOTAL-1.
REQ-013 yPos  out  10  current vertical count, 0..V_TOTAL-1.
REQ-014 VGA_HS, VGA_VS  out  1 each  sync pulses, active-low.
REQ-015 VGA_R, VGA_G, VGA_B  out  4 each  DAC colour, blanked outside the visible area.
REQ-016 frame_start  out  1  one-clock pulse at the first pixel of each frame.

Function
REQ-017 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal the sum of the V parameters (525).
REQ-018 The horizontal counter SHALL increment every vga_clk and wrap from H_TOTAL-1 to 0.
REQ-019 The vertical counter SHALL increment only on the clock where the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 to 0 on the same clock that the horizontal counter wraps.
REQ-020 xPos and yPos SHALL be the registered counter values.
REQ-021 A horizontal phase FSM SHALL step H_ACTIVE->H_FRONT->H_SYNC->H_BACK->H_ACTIVE, each transition on the last count of its phase; a vertical FSM SHALL follow the same order (V_ACTIVE/V_FRONT/V_SYNC/V_BACK) and advance only at horizontal wrap.
REQ-022 visible SHALL equal (xPos<H_VISIBLE && yPos<V_VISIBLE).
REQ-023 The raw hsync SHALL be low exactly when xPos is in [656,751]; the raw vsync SHALL be low exactly when yPos is in [490,491].
REQ-024 VGA_HS, VGA_VS and the blank flag SHALL be delayed by one register stage so they align with red_in/green_in/blue_in (pipeline latency 1 clock from xPos/yPos).
REQ-025 VGA_R/G/B SHALL be registered, equal red_in[3:0]/green_in[3:0]/blue_in[3:0] when the delayed visible flag is 1, and 0 otherwise.
REQ-026 frame_start SHALL be 1 for exactly one clock, asserted on the clock where xPos=0 and yPos=0 are presented.
REQ-027 Counter arithmetic SHALL be 10-bit unsigned, and the counters SHALL never exceed H_TOTAL-1/V_TOTAL-1.

Reset
REQ-028 While RST=0: counters and FSMs SHALL be 0 / H_ACTIVE / V_ACTIVE, VGA_HS=VGA_VS=1, VGA_R/G/B=0, frame_start=0.
REQ-029 Reset asserted mid-frame SHALL take effect immediately (asynchronously), and no partial sync pulse SHALL be driven after it.
REQ-030 After RST rises, the first clock SHALL present xPos=0, yPos=0 with frame_start=1.

Structure
REQ-031 A shared package vga_timing_pkg SHALL hold the 640x480@60 timing constants and the phase-state encodings.
REQ-032 One sub-module, vga_phase_counter (counter + phase FSM for one axis, with a wrap-out strobe), SHALL be instantiated twice: horizontal, and vertical enabled by the horizontal wrap.

Verification
REQ-033 Release reset, run 800 clocks -> xPos 0..799 then 0, yPos increments 0->1 exactly once.
REQ-034 Run one full frame (420000 clocks) -> exactly one frame_start, 525 VGA_HS low pulses of 96 clocks each, one VGA_VS low pulse of 1600 clocks.
REQ-035 Drive red_in=10'h00F constantly -> VGA_R=4'hF exactly when the delayed (xPos<640, yPos<480), VGA_R=0 during porches/sync.
REQ-036 Drive the white band pattern (yPos 236..244) -> VGA_R/G/B=4'hF only on lines 236..244, one clock after each visible xPos.
REQ-037 Assert RST at xPos=700, yPos=490 (inside a sync pulse) -> VGA_HS and VGA_VS rise to 1 without waiting for a clock edge; after release, xPos=0, yPos=0.
REQ-038 Check the wrap at xPos=799, yPos=524 -> the next clock gives xPos=0, yPos=0 and frame_start=1.
